// File: rtl/pipeline_flow_pkg.sv
// Shared defaults, legality limits and sizing helpers for the pipeline flow adapter.
package pipeline_flow_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_DEPTH   = 4;

    localparam int MIN_LATENCY = 1;
    localparam int MAX_LATENCY = 16;
    localparam int MIN_DEPTH   = 1;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int latency, input int depth);
        return (latency >= MIN_LATENCY) && (latency <= MAX_LATENCY) && (depth >= MIN_DEPTH);
    endfunction

endpackage

// File: rtl/pipeline_flow_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty flags.
module pipeline_flow_fifo
    import pipeline_flow_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_idx, rd_idx, wr_idx_n, rd_idx_n;
    logic              wr_wrap, rd_wrap, wr_wrap_n, rd_wrap_n;
    logic              do_push, do_pop;

    // A pop on a full FIFO frees the slot first, so the push may land in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_idx_n  = wr_idx;
        wr_wrap_n = wr_wrap;
        rd_idx_n  = rd_idx;
        rd_wrap_n = rd_wrap;
        if (do_push) begin
            if (wr_idx == AW'(DEPTH - 1)) begin
                wr_idx_n  = '0;
                wr_wrap_n = !wr_wrap;
            end else begin
                wr_idx_n = wr_idx + 1'b1;
            end
        end
        if (do_pop) begin
            if (rd_idx == AW'(DEPTH - 1)) begin
                rd_idx_n  = '0;
                rd_wrap_n = !rd_wrap;
            end else begin
                rd_idx_n = rd_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            wr_idx  <= wr_idx_n;
            rd_idx  <= rd_idx_n;
            wr_wrap <= wr_wrap_n;
            rd_wrap <= rd_wrap_n;
            empty   <= (wr_idx_n == rd_idx_n) && (wr_wrap_n == rd_wrap_n);
            full    <= (wr_idx_n == rd_idx_n) && (wr_wrap_n != rd_wrap_n);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    assign head = mem[rd_idx];

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/pipeline_flow_adapter.sv
// Ready/valid wrapper around a fixed-latency, non-stalling pipeline; credits bound
// in-flight plus buffered results to the egress FIFO depth.
module pipeline_flow_adapter
    import pipeline_flow_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int LATENCY = DEF_LATENCY,
    parameter  int DEPTH   = DEF_DEPTH,
    localparam int OCC_W   = occ_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] pipe_in_data,
    output logic              pipe_in_valid,
    input  logic [DATA_W-1:0] pipe_out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    logic [LATENCY-1:0] vsr;
    logic               fire_in, pop;
    logic               cap_valid;
    logic [DATA_W-1:0]  cap_data;
    logic               fifo_full, fifo_empty;
    logic [DATA_W-1:0]  fifo_head;

    // in_ready comes only from the occupancy register, never from out_ready.
    assign in_ready      = (occupancy < OCC_W'(DEPTH));
    assign fire_in       = in_valid && in_ready;
    assign pipe_in_data  = in_data;
    assign pipe_in_valid = fire_in;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_head : '0;

    // The final-stage result is captured the cycle its flag arrives and written into
    // the FIFO on the next edge, giving LATENCY+1 cycles from accept to out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsr       <= '0;
            cap_valid <= 1'b0;
            occupancy <= '0;
        end else begin
            vsr[0] <= fire_in;
            for (int i = 1; i < LATENCY; i++) begin
                vsr[i] <= vsr[i-1];
            end
            cap_valid <= vsr[LATENCY-1];
            occupancy <= occupancy + OCC_W'(fire_in) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (vsr[LATENCY-1]) begin
            cap_data <= pipe_out_data;
        end
    end

    pipeline_flow_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_valid),
        .push_data (cap_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always @(posedge clk) begin
        if (!rst) begin
            assert (params_legal(LATENCY, DEPTH));
            assert (occupancy <= OCC_W'(DEPTH));
            assert (!(cap_valid && fifo_full));
        end
    end

endmodule

// File: tb/tb_pipeline_flow_adapter.sv
// Directed bench for pipeline_flow_adapter with a 2-stage +7 pipeline model.
module tb_pipeline_flow_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] pipe_in_data;
    logic        pipe_in_valid;
    logic [31:0] pipe_out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  occupancy;

    logic [31:0] p0;
    logic [31:0] got[$];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p0            <= pipe_in_data + 32'd7;
        pipe_out_data <= p0;
    end

    pipeline_flow_adapter #(
        .DATA_W  (32),
        .LATENCY (2),
        .DEPTH   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .pipe_in_data  (pipe_in_data),
        .pipe_in_valid (pipe_in_valid),
        .pipe_out_data (pipe_out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .occupancy     (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Records the beat consumed at the coming edge, then steps to 1ns past it.
    task automatic cyc();
        if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d, acc, sent, bad, comb_err, max_occ;
        logic r;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", out_data, 32'd0);
        check("rst_occupancy", {29'd0, occupancy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three back-to-back transactions, latency LATENCY+1.
        got.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h10;
        #1;
        check("s1_pipe_in_valid", {31'd0, pipe_in_valid}, 32'd1);
        check("s1_pipe_in_data", pipe_in_data, 32'h10);
        cyc();
        in_data = 32'h11;
        cyc();
        in_data = 32'h12;
        cyc();
        in_valid = 1'b0;
        check("s1_no_early_valid", {31'd0, out_valid}, 32'd0);
        cyc();
        check("s1_valid_edge3", {31'd0, out_valid}, 32'd1);
        check("s1_data0", out_data, 32'h17);
        check("s1_occ3", {29'd0, occupancy}, 32'd3);
        cyc();
        check("s1_data1", out_data, 32'h18);
        cyc();
        check("s1_data2", out_data, 32'h19);
        cyc();
        check("s1_drained_valid", {31'd0, out_valid}, 32'd0);
        check("s1_occ0", {29'd0, occupancy}, 32'd0);
        check("s1_count", got.size(), 32'd3);

        // Back-pressure: only DEPTH credits available.
        got.delete();
        out_ready = 1'b0;
        d   = 1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = d;
            if (in_ready) begin
                acc++;
                d++;
            end
            cyc();
        end
        check("s2_accepted", acc, 32'd4);
        check("s2_occ", {29'd0, occupancy}, 32'd4);
        check("s2_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("s2_head", out_data, 32'h8);
        cyc();
        check("s2_head_stable", out_data, 32'h8);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            in_valid = (d <= 6);
            in_data  = d;
            if (in_valid && in_ready) d++;
            cyc();
        end
        in_valid = 1'b0;
        check("s2_count", got.size(), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("s2_order%0d", i), got[i], 32'(i + 8));

        // 100-item stream with alternating out_ready and a mid-cycle out_ready wiggle.
        got.delete();
        sent     = 0;
        comb_err = 0;
        max_occ  = 0;
        for (int c = 0; c < 1000 && got.size() < 100; c++) begin
            out_ready = (c % 2 == 0);
            in_valid  = (sent < 100);
            in_data   = 32'h100 + sent;
            r = in_ready;
            out_ready = !out_ready;
            #1;
            if (in_ready !== r) comb_err++;
            out_ready = !out_ready;
            #1;
            if (int'(occupancy) > max_occ) max_occ = occupancy;
            if (in_valid && in_ready) sent++;
            cyc();
        end
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] !== 32'h107 + i) bad++;
        check("s3_count", got.size(), 32'd100);
        check("s3_order_errors", bad, 32'd0);
        check("s3_comb_in_ready", comb_err, 32'd0);
        check("s3_max_occ_le_depth", {31'd0, max_occ <= 4}, 32'd1);
        check("s3_occ_end", {29'd0, occupancy}, 32'd0);

        // Full FIFO, then simultaneous accept and pop.
        got.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h20 + k;
            cyc();
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        check("s4_full_occ", {29'd0, occupancy}, 32'd4);
        check("s4_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("s4_full_head", out_data, 32'h27);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h24;
        cyc();
        check("s4_pop_only_occ", {29'd0, occupancy}, 32'd3);
        check("s4_credit_back", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        check("s4_push_pop_occ", {29'd0, occupancy}, 32'd3);
        check("s4_head_after2", out_data, 32'h29);
        for (int c = 0; c < 20 && occupancy != 0; c++) cyc();
        check("s4_count", got.size(), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("s4_order%0d", i), got[i], 32'(32'h27 + i));

        // Reset with two in flight and one buffered.
        got.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h30;
        cyc();
        in_valid = 1'b0;
        cyc();
        in_valid = 1'b1;
        in_data  = 32'h31;
        cyc();
        in_data = 32'h32;
        cyc();
        in_valid = 1'b0;
        check("s5_pre_valid", {31'd0, out_valid}, 32'd1);
        check("s5_pre_occ", {29'd0, occupancy}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("s5_async_valid", {31'd0, out_valid}, 32'd0);
        check("s5_async_occ", {29'd0, occupancy}, 32'd0);
        check("s5_async_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        check("s5_post_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (10) cyc();
        check("s5_no_stale", got.size(), 32'd0);
        check("s5_post_occ", {29'd0, occupancy}, 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h40;
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        check("s5_recover_count", got.size(), 32'd1);
        check("s5_recover_data", got[0], 32'h47);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
